// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, register index, opcode and the MEM stage FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef logic [5:0]  opcode_t;

    localparam opcode_t BEQ = 6'b000100;
    localparam opcode_t BNE = 6'b000101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HALTED
    } memstate_t;

    typedef struct packed {
        logic     regwrite;
        logic     memtoreg;
        regbits_t wsel;
        word_t    aluout;
        word_t    load;
        word_t    npc;
        logic     halt;
    } mem_wb_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational branch/jump resolution: decides whether the instruction redirects and where.
module branch_resolve
    import cpu_types_pkg::*;
(
    input  word_t       cpc,
    input  logic        branch,
    input  logic        zflag,
    input  logic [1:0]  jump,
    input  word_t       imm,
    input  word_t       regtarget,
    input  logic [25:0] jaddr,
    input  opcode_t     opcode,
    output logic        take,
    output word_t       target
);

    word_t npc;

    always_comb begin
        npc    = cpc + 32'd4;
        take   = 1'b0;
        target = '0;
        unique case (jump)
            2'b00: begin
                take   = branch & (((opcode == BEQ) & zflag) | ((opcode == BNE) & ~zflag));
                target = npc + (imm << 2);
            end
            2'b01: begin
                take   = 1'b1;
                target = {npc[31:28], jaddr, 2'b00};
            end
            2'b10: begin
                take   = 1'b1;
                target = regtarget;
            end
            default: ;  // jump=11 is reserved: never redirects
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-cache handshake FSM, MEM/WB register and PC redirect.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  word_t       cpc,
    input  logic        regWrite,
    input  logic        memtoReg,
    input  logic        halt,
    input  logic        branch,
    input  logic        zflag,
    input  logic        dren,
    input  logic        dwen,
    input  logic [1:0]  jump,
    input  word_t       aluout,
    input  word_t       writeData,
    input  word_t       imm,
    input  word_t       regtarget,
    input  regbits_t    wsel,
    input  logic [25:0] jaddr,
    input  opcode_t     opcode,
    input  logic        en,
    output logic        dmemREN,
    output logic        dmemWEN,
    output word_t       dmemaddr,
    output word_t       dmemstore,
    input  logic        dhit,
    input  word_t       dmemload,
    output logic        dstall,
    output logic        redirect,
    output word_t       redirect_pc,
    output logic        wb_regWrite,
    output logic        wb_memtoReg,
    output regbits_t    wb_wsel,
    output word_t       wb_aluout,
    output word_t       wb_load,
    output word_t       wb_npc,
    output logic        wb_halt
);

    memstate_t state_q, state_d;
    mem_wb_t   wb_q, wb_d, pend_q, pend_d, cur;
    logic      pend_vld_q, pend_vld_d;
    logic      is_rd, is_wr, mem_op, take;
    word_t     target;

    // Both enables high is a write.
    assign is_wr  = dwen;
    assign is_rd  = dren & ~dwen;
    assign mem_op = dren | dwen;

    branch_resolve u_branch_resolve (
        .cpc       (cpc),
        .branch    (branch),
        .zflag     (zflag),
        .jump      (jump),
        .imm       (imm),
        .regtarget (regtarget),
        .jaddr     (jaddr),
        .opcode    (opcode),
        .take      (take),
        .target    (target)
    );

    always_comb begin
        cur.regwrite = regWrite & ~halt;
        cur.memtoreg = memtoReg;
        cur.wsel     = wsel;
        cur.aluout   = aluout;
        cur.load     = is_rd ? dmemload : '0;
        cur.npc      = cpc + 32'd4;
        cur.halt     = halt;
    end

    always_comb begin
        state_d    = state_q;
        wb_d       = wb_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        dstall     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A result finished under en=0 goes out before anything new starts.
                if (pend_vld_q) begin
                    if (en) begin
                        wb_d       = pend_q;
                        pend_vld_d = 1'b0;
                    end
                end else if (halt) begin
                    if (en) begin
                        wb_d    = cur;
                        state_d = HALTED;
                    end
                end else if (mem_op) begin
                    dstall = 1'b1;
                    if (en) state_d = WAIT;
                end else if (en) begin
                    wb_d = cur;
                end
            end
            WAIT: begin
                dmemREN   = is_rd;
                dmemWEN   = is_wr;
                dmemaddr  = aluout;
                dmemstore = writeData;
                if (dhit) begin
                    state_d = IDLE;
                    if (en) begin
                        wb_d = cur;
                    end else begin
                        pend_d     = cur;
                        pend_vld_d = 1'b1;
                    end
                end else begin
                    dstall = 1'b1;
                end
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase
        if (!nRST) begin
            dmemREN = 1'b0;
            dmemWEN = 1'b0;
            dstall  = 1'b0;
        end
    end

    assign redirect    = nRST & en & ~dstall & (state_q != HALTED) & take;
    assign redirect_pc = redirect ? target : '0;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q    <= IDLE;
            wb_q       <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_q       <= wb_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign wb_regWrite = wb_q.regwrite;
    assign wb_memtoReg = wb_q.memtoreg;
    assign wb_wsel     = wb_q.wsel;
    assign wb_aluout   = wb_q.aluout;
    assign wb_load     = wb_q.load;
    assign wb_npc      = wb_q.npc;
    assign wb_halt     = wb_q.halt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    word_t       cpc, aluout, writeData, imm, regtarget, dmemload;
    logic        regWrite, memtoReg, halt, branch, zflag, dren, dwen, en, dhit;
    logic [1:0]  jump;
    logic [25:0] jaddr;
    opcode_t     opcode;
    regbits_t    wsel, wb_wsel;
    logic        dmemREN, dmemWEN, dstall, redirect;
    word_t       dmemaddr, dmemstore, redirect_pc, wb_aluout, wb_load, wb_npc;
    logic        wb_regWrite, wb_memtoReg, wb_halt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    mem_stage dut (
        .CLK(CLK), .nRST(nRST), .cpc(cpc), .regWrite(regWrite), .memtoReg(memtoReg),
        .halt(halt), .branch(branch), .zflag(zflag), .dren(dren), .dwen(dwen), .jump(jump),
        .aluout(aluout), .writeData(writeData), .imm(imm), .regtarget(regtarget), .wsel(wsel),
        .jaddr(jaddr), .opcode(opcode), .en(en), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .dmemaddr(dmemaddr), .dmemstore(dmemstore), .dhit(dhit), .dmemload(dmemload),
        .dstall(dstall), .redirect(redirect), .redirect_pc(redirect_pc),
        .wb_regWrite(wb_regWrite), .wb_memtoReg(wb_memtoReg), .wb_wsel(wb_wsel),
        .wb_aluout(wb_aluout), .wb_load(wb_load), .wb_npc(wb_npc), .wb_halt(wb_halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear();
        cpc = '0; regWrite = 0; memtoReg = 0; halt = 0; branch = 0; zflag = 0;
        dren = 0; dwen = 0; jump = 2'b00; aluout = '0; writeData = '0; imm = '0;
        regtarget = '0; wsel = '0; jaddr = '0; opcode = '0; en = 1; dhit = 0; dmemload = '0;
    endtask

    // Reference: where a non-memory instruction should send the PC.
    task automatic model_redirect(output logic red, output word_t pc);
        word_t npc;
        npc = cpc + 32'd4;
        red = 1'b0;
        pc  = '0;
        if (jump == 2'b01) begin
            red = 1'b1; pc = {npc[31:28], jaddr, 2'b00};
        end else if (jump == 2'b10) begin
            red = 1'b1; pc = regtarget;
        end else if (jump == 2'b00 && branch) begin
            red = (opcode == BEQ) ? zflag : (opcode == BNE) ? !zflag : 1'b0;
            pc  = npc + imm * 32'd4;
        end
    endtask

    initial begin
        logic  e_red;
        word_t e_pc;
        word_t e_load;
        int    kind, lat;

        nRST = 1'b0;
        clear();
        branch = 1; opcode = BEQ; zflag = 1; cpc = 32'h40;
        #12;
        chk("rst_redirect", redirect, 0);
        chk("rst_dstall", dstall, 0);
        chk("rst_wb_npc", wb_npc, 0);
        chk("rst_wb_halt", wb_halt, 0);
        clear();
        nRST = 1'b1;
        tick();

        // LW with dhit in the third cycle
        aluout = 32'h100; dren = 1; regWrite = 1; memtoReg = 1; wsel = 5'd5; cpc = 32'h1000;
        dmemload = 32'hDEADBEEF;
        #1 chk("lw_c1_dstall", dstall, 1);
        tick();
        chk("lw_c2_dstall", dstall, 1);
        chk("lw_c2_ren", dmemREN, 1);
        chk("lw_c2_addr", dmemaddr, 32'h100);
        tick();
        dhit = 1;
        #1 chk("lw_c3_dstall", dstall, 0);
        tick();
        chk("lw_wb_load", wb_load, 32'hDEADBEEF);
        chk("lw_wb_memtoreg", wb_memtoReg, 1);
        chk("lw_wb_regwrite", wb_regWrite, 1);
        chk("lw_wb_wsel", wb_wsel, 5);
        chk("lw_wb_npc", wb_npc, 32'h1004);
        clear();

        // SW, with dren also high so the write must win
        aluout = 32'h200; writeData = 32'h12345678; dwen = 1; dren = 1; cpc = 32'h1100;
        tick();
        chk("sw_wen", dmemWEN, 1);
        chk("sw_ren", dmemREN, 0);
        chk("sw_store", dmemstore, 32'h12345678);
        chk("sw_addr", dmemaddr, 32'h200);
        tick();
        chk("sw_wen_hold", dmemWEN, 1);
        dhit = 1;
        tick();
        chk("sw_wb_regwrite", wb_regWrite, 0);
        chk("sw_wb_npc", wb_npc, 32'h1104);
        clear();
        #1 chk("sw_wen_done", dmemWEN, 0);

        // BEQ / J / JR / reserved jump / en gating
        cpc = 32'h40; imm = 32'hFFFFFFFE; zflag = 1; branch = 1; opcode = BEQ;
        #1 chk("beq_taken", redirect, 1);
        chk("beq_pc", redirect_pc, 32'h3C);
        zflag = 0;
        #1 chk("beq_not_taken", redirect, 0);
        opcode = BNE;
        #1 chk("bne_taken", redirect, 1);
        en = 0;
        #1 chk("bne_en_gated", redirect, 0);
        clear();
        cpc = 32'hF0000010; jump = 2'b01; jaddr = 26'h0000100;
        #1 chk("j_pc", redirect_pc, 32'hF0000400);
        jump = 2'b10; regtarget = 32'h88;
        #1 chk("jr_pc", redirect_pc, 32'h88);
        jump = 2'b11;
        #1 chk("jump11_redirect", redirect, 0);
        clear();
        tick();

        // Known ALU result, then a load completing under en=0 goes to the pending register
        aluout = 32'h55; cpc = 32'h2000; regWrite = 1; wsel = 5'd3;
        tick();
        chk("alu_wb_aluout", wb_aluout, 32'h55);
        clear();
        aluout = 32'h104; dren = 1; regWrite = 1; memtoReg = 1; cpc = 32'h3000;
        tick();
        en = 0;
        tick();
        dhit = 1; dmemload = 32'hCAFEF00D;
        tick();
        dhit = 0; dmemload = 32'h0;
        chk("pend_hold_npc", wb_npc, 32'h2004);
        chk("pend_hold_aluout", wb_aluout, 32'h55);
        en = 1;
        #1 chk("pend_dstall", dstall, 0);
        tick();
        chk("pend_rel_load", wb_load, 32'hCAFEF00D);
        chk("pend_rel_npc", wb_npc, 32'h3004);
        clear();

        // Randomized instruction stream
        for (int i = 0; i < 40; i++) begin
            clear();
            kind      = int'($urandom_range(0, 4));
            cpc       = $urandom() & 32'hFFFF_FFFC;
            aluout    = $urandom();
            writeData = $urandom();
            imm       = $urandom();
            regtarget = $urandom();
            jaddr     = 26'($urandom());
            wsel      = 5'($urandom());
            regWrite  = 1'($urandom());
            memtoReg  = 1'($urandom());
            case (kind)
                1: begin
                    branch = 1; zflag = 1'($urandom());
                    opcode = $urandom_range(0, 1) ? BEQ : BNE;
                end
                2: jump = 2'($urandom_range(1, 3));
                3: dren = 1;
                4: begin dwen = 1; dren = 1'($urandom()); regWrite = 0; end
                default: ;
            endcase
            if (kind >= 3) begin
                lat    = int'($urandom_range(1, 4));
                e_load = $urandom();
                #1 chk("rnd_idle_dstall", dstall, 1);
                tick();
                for (int k = 1; k < lat; k++) begin
                    chk("rnd_wait_dstall", dstall, 1);
                    chk("rnd_wait_ren", dmemREN, (kind == 3));
                    chk("rnd_wait_wen", dmemWEN, (kind == 4));
                    chk("rnd_wait_addr", dmemaddr, aluout);
                    tick();
                end
                dhit = 1; dmemload = e_load;
                #1 chk("rnd_hit_dstall", dstall, 0);
                tick();
                chk("rnd_mem_load", wb_load, (kind == 3) ? e_load : 32'h0);
                chk("rnd_mem_regwrite", wb_regWrite, regWrite);
            end else begin
                model_redirect(e_red, e_pc);
                #1 chk("rnd_redirect", redirect, e_red);
                if (e_red) chk("rnd_redirect_pc", redirect_pc, e_pc);
                tick();
                chk("rnd_wb_aluout", wb_aluout, aluout);
                chk("rnd_wb_load", wb_load, 0);
            end
            chk("rnd_wb_npc", wb_npc, cpc + 32'd4);
            chk("rnd_wb_wsel", wb_wsel, wsel);
        end
        clear();

        // Reset in the middle of a load
        aluout = 32'h300; dren = 1; cpc = 32'h4000;
        tick();
        #1 chk("rstw_ren_before", dmemREN, 1);
        nRST = 0;
        #1 chk("rstw_ren", dmemREN, 0);
        chk("rstw_dstall", dstall, 0);
        chk("rstw_wb_npc", wb_npc, 0);
        chk("rstw_wb_aluout", wb_aluout, 0);
        chk("rstw_wb_load", wb_load, 0);
        clear();
        nRST = 1;
        tick();
        cpc = 32'h500; aluout = 32'h77;
        #1 chk("rstw_idle_dstall", dstall, 0);
        tick();
        chk("rstw_after_npc", wb_npc, 32'h504);
        clear();

        // Halt is sticky
        halt = 1; regWrite = 1; cpc = 32'h600;
        tick();
        chk("halt_wb_halt", wb_halt, 1);
        chk("halt_wb_regwrite", wb_regWrite, 0);
        chk("halt_wb_npc", wb_npc, 32'h604);
        clear();
        dren = 1; aluout = 32'h100;
        for (int k = 0; k < 3; k++) begin
            #1 chk("halt_ren", dmemREN, 0);
            chk("halt_dstall", dstall, 0);
            tick();
        end
        dren = 0; branch = 1; opcode = BEQ; zflag = 1;
        #1 chk("halt_redirect", redirect, 0);
        chk("halt_sticky", wb_halt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
